cfi_log_queue: RTL and testbench
================================

Name: cfi_log_queue

Overview:
- Multi-port log buffer between commit-side CFI filtering and the CFI backend.
- Each cycle it accepts up to NR_COMMIT_PORTS filtered control-flow logs, compacts them in port order and writes them into a circular buffer.
- It presents entries one at a time to the backend over a valid/ready handshake.
- It replaces the single-push queue controller plus FIFO pair. It adds multi-push per cycle, selectable halt/drop overflow policy, flush, usage reporting and a saturating overflow counter.

Parameters:
- NR_COMMIT_PORTS, 2, number of commit ports (1..4).
- NR_ENTRIES, 8, buffer depth; power of two, >= NR_COMMIT_PORTS.
- LOG_W, 64, width of one log entry in bits.
- HALT_ON_FULL, 1, overflow policy: 1 = request commit stall via cfi_halt_o; 0 = never stall, drop excess logs.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- log_i  in  NR_COMMIT_PORTS*LOG_W  per-port log payloads; port p occupies bits [p*LOG_W +: LOG_W].
- log_cfi_i  in  NR_COMMIT_PORTS  port p carries a control-flow log.
- log_ack_i  in  NR_COMMIT_PORTS  port p commits this cycle.
- flush_i  in  1  synchronous clear of buffer contents.
- cfi_halt_o  out  1  commit stall request.
- out_valid_o  out  1  head entry available.
- out_ready_i  in  1  backend consumes head entry.
- out_data_o  out  LOG_W  head entry payload.
- usage_o  out  $clog2(NR_ENTRIES)+1  occupied entries.
- overflow_cnt_o  out  16  logs lost to overflow, saturating.

Behaviour:
- Reset (async, rst_ni=0):
  - wr_ptr = rd_ptr = 0, usage = 0, overflow_cnt = 0.
  - Outputs: out_valid_o=0, cfi_halt_o=0, usage_o=0, overflow_cnt_o=0. out_data_o don't-care.
  - Storage array is not reset.
- Candidates:
  - cand[p] = log_cfi_i[p] & log_ack_i[p]; k = popcount(cand).
  - free = NR_ENTRIES - usage, taken from registered state; a same-cycle pop does not add space.
- Push:
  - a = min(k, free).
  - The first a candidates in ascending port order are written to slots wr_ptr, wr_ptr+1, ... modulo NR_ENTRIES.
  - The remaining k-a candidates are lost; overflow_cnt += (k-a), saturating at 16'hFFFF.
  - wr_ptr advances by a, wrapping modulo NR_ENTRIES.
- Halt (combinational):
  - cfi_halt_o = HALT_ON_FULL & (popcount(log_cfi_i) > free).
  - Depends on log_cfi_i only, not log_ack_i, so no combinational loop through commit.
  - With HALT_ON_FULL=0, cfi_halt_o is constant 0.
  - If commit acks despite halt, the push/drop rule above still applies and the overflow count records the loss.
- Output side:
  - out_valid_o = (usage != 0); out_data_o = mem[rd_ptr].
  - Pop occurs when out_valid_o & out_ready_i; rd_ptr advances by 1 with wrap.
  - No bypass: an entry pushed in cycle t is visible at the head no earlier than cycle t+1.
  - Payload is held stable while valid and not ready.
- Simultaneous push and pop: usage_next = usage + a - pop. Push space is limited by pre-pop free, so no overwrite of the head.
- Flush:
  - flush_i=1 sets wr_ptr = rd_ptr = 0 and usage = 0 next cycle.
  - Push and pop in the same cycle are ignored and do not count as overflow.
  - overflow_cnt is not cleared.
  - cfi_halt_o during flush follows the normal formula on the current state.
- Invariants: usage <= NR_ENTRIES always; out_valid_o=0 implies no pop.
- Reset asserted mid-operation: all state returns to reset values immediately; contents are discarded.

Test Plan (NR_COMMIT_PORTS=2, NR_ENTRIES=4, LOG_W=8 unless noted):
- Dual push: cfi=2'b11, ack=2'b11, log1=0xB1, log0=0xA0, out_ready_i=0 → next cycle usage_o=2, out_valid_o=1, out_data_o=0xA0. Then out_ready_i=1 for one cycle → out_data_o=0xB1, usage_o=1.
- Sparse compaction: cfi=2'b10, ack=2'b11, log1=0x55 → only 0x55 stored, usage_o=1, out_data_o=0x55.
- Halt: with usage=3, cfi=2'b11 → cfi_halt_o=1 in the same cycle. With cfi=2'b01 → cfi_halt_o=0, and push fills the buffer to usage_o=4.
- Drop mode (HALT_ON_FULL=0): with usage=3, cfi=ack=2'b11, log0=0x11, log1=0x22 → 0x11 stored, 0x22 dropped, overflow_cnt_o=1, cfi_halt_o=0. Repeat with usage=4 → overflow_cnt_o=3.
- Wrap and concurrency: 6 single pushes interleaved with pops, with push and pop in the same cycle at usage=2 → usage_o stays 2; FIFO order preserved across pointer wrap.
- Flush and reset:
  - With usage=3, flush_i=1 together with cfi=ack=2'b01 → next cycle usage_o=0, out_valid_o=0, overflow_cnt_o unchanged.
  - Drop rst_ni mid-stream → outputs zero asynchronously.

Source files
------------

// File: rtl/cfi_log_queue.sv
// Multi-port CFI log buffer: compacts up to NR_COMMIT_PORTS committed logs per
// cycle into a circular buffer and streams them to the backend over valid/ready.
module cfi_log_queue #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned LOG_W           = 64,
  parameter bit          HALT_ON_FULL    = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NR_COMMIT_PORTS*LOG_W-1:0] log_i,
  input  logic [NR_COMMIT_PORTS-1:0]       log_cfi_i,
  input  logic [NR_COMMIT_PORTS-1:0]       log_ack_i,
  input  logic                             flush_i,
  output logic                             cfi_halt_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [LOG_W-1:0]                 out_data_o,
  output logic [$clog2(NR_ENTRIES):0]      usage_o,
  output logic [15:0]                      overflow_cnt_o
);

  localparam int unsigned PTR_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int unsigned USE_W = $clog2(NR_ENTRIES) + 1;

  logic [LOG_W-1:0]           mem [NR_ENTRIES];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [USE_W-1:0]           usage;
  logic [15:0]                overflow_cnt;

  logic [NR_COMMIT_PORTS-1:0] cand;
  logic [NR_COMMIT_PORTS-1:0] push_en;
  logic [USE_W-1:0]           rank [NR_COMMIT_PORTS];
  logic [PTR_W-1:0]           slot [NR_COMMIT_PORTS];
  logic [USE_W-1:0]           k, cfi_cnt, free, a, dropped;
  logic [16:0]                ovf_sum;
  logic                       pop;

  // rank[p] is the number of candidates on lower ports, i.e. p's compacted offset.
  always_comb begin
    cand    = log_cfi_i & log_ack_i;
    free    = USE_W'(NR_ENTRIES) - usage;
    k       = '0;
    cfi_cnt = '0;
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      rank[p]    = k;
      push_en[p] = cand[p] && (k < free);
      slot[p]    = wr_ptr + PTR_W'(k);
      if (cand[p])      k       = k + USE_W'(1);
      if (log_cfi_i[p]) cfi_cnt = cfi_cnt + USE_W'(1);
    end
    a       = (k < free) ? k : free;
    dropped = k - a;
    ovf_sum = 17'(overflow_cnt) + 17'(dropped);
    pop     = (usage != '0) && out_ready_i;
  end

  assign cfi_halt_o     = HALT_ON_FULL && (cfi_cnt > free);
  assign out_valid_o    = (usage != '0);
  assign out_data_o     = mem[rd_ptr];
  assign usage_o        = usage;
  assign overflow_cnt_o = overflow_cnt;

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (!flush_i && push_en[p]) begin
        mem[slot[p]] <= log_i[p*LOG_W +: LOG_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usage        <= '0;
      overflow_cnt <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      wr_ptr       <= wr_ptr + PTR_W'(a);
      rd_ptr       <= rd_ptr + PTR_W'(pop);
      usage        <= usage + a - USE_W'(pop);
      overflow_cnt <= ovf_sum[16] ? '1 : ovf_sum[15:0];
    end
  end

endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed bench for cfi_log_queue: one halt-mode and one drop-mode instance
// driven with identical stimulus.
module tb_cfi_log_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] log_in;
  logic [1:0]  cfi;
  logic [1:0]  ack;
  logic        flush;
  logic        ready;

  logic        halt_h, valid_h, halt_d, valid_d;
  logic [7:0]  data_h, data_d;
  logic [2:0]  usage_h, usage_d;
  logic [15:0] ovf_h, ovf_d;

  int unsigned vectors;
  int unsigned miscompares;

  cfi_log_queue #(
    .NR_COMMIT_PORTS(2),
    .NR_ENTRIES     (4),
    .LOG_W          (8),
    .HALT_ON_FULL   (1'b1)
  ) dut_h (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .log_i         (log_in),
    .log_cfi_i     (cfi),
    .log_ack_i     (ack),
    .flush_i       (flush),
    .cfi_halt_o    (halt_h),
    .out_valid_o   (valid_h),
    .out_ready_i   (ready),
    .out_data_o    (data_h),
    .usage_o       (usage_h),
    .overflow_cnt_o(ovf_h)
  );

  cfi_log_queue #(
    .NR_COMMIT_PORTS(2),
    .NR_ENTRIES     (4),
    .LOG_W          (8),
    .HALT_ON_FULL   (1'b0)
  ) dut_d (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .log_i         (log_in),
    .log_cfi_i     (cfi),
    .log_ack_i     (ack),
    .flush_i       (flush),
    .cfi_halt_o    (halt_d),
    .out_valid_o   (valid_d),
    .out_ready_i   (ready),
    .out_data_o    (data_d),
    .usage_o       (usage_d),
    .overflow_cnt_o(ovf_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfi   = 2'b00;
    ack   = 2'b00;
    ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] l1, input logic [7:0] l0);
    cfi    = c;
    ack    = c;
    log_in = {l1, l0};
    step();
    idle();
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, 32'(data_h), 32'(exp));
    ready = 1'b1;
    step();
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    log_in      = '0;
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_usage", 32'(usage_h), 32'd0);
    chk("rst_valid", 32'(valid_h), 32'd0);
    chk("rst_halt",  32'(halt_h),  32'd0);
    chk("rst_ovf",   32'(ovf_h),   32'd0);
    rst_n = 1'b1;
    step();

    // Dual push, then pop in order
    cfi = 2'b11; ack = 2'b11; log_in = {8'hB1, 8'hA0};
    #1 chk("dual_halt", 32'(halt_h), 32'd0);
    step(); idle();
    chk("dual_usage", 32'(usage_h), 32'd2);
    chk("dual_valid", 32'(valid_h), 32'd1);
    chk("dual_head",  32'(data_h),  32'hA0);
    ready = 1'b1; step(); idle();
    chk("dual_head2",  32'(data_h),  32'hB1);
    chk("dual_usage2", 32'(usage_h), 32'd1);
    ready = 1'b1; step(); idle();
    chk("dual_empty", 32'(valid_h), 32'd0);

    // Sparse compaction: only port 1 is a committed CFI log
    cfi = 2'b10; ack = 2'b11; log_in = {8'h55, 8'hEE};
    step(); idle();
    chk("sparse_usage", 32'(usage_h), 32'd1);
    chk("sparse_head",  32'(data_h),  32'h55);
    ready = 1'b1; step(); idle();
    chk("sparse_empty", 32'(usage_h), 32'd0);

    // Halt threshold at usage 3, fill to full, drain across wrap
    push(2'b11, 8'h02, 8'h01);
    push(2'b01, 8'h00, 8'h03);
    chk("halt_usage3", 32'(usage_h), 32'd3);
    cfi = 2'b11;
    #1 chk("halt_two",    32'(halt_h), 32'd1);
    chk("halt_two_drop",  32'(halt_d), 32'd0);
    cfi = 2'b01;
    #1 chk("halt_one",    32'(halt_h), 32'd0);
    ack = 2'b01; log_in = {8'h00, 8'h04};
    step();
    chk("halt_full_usage", 32'(usage_h), 32'd4);
    #1 chk("halt_full",    32'(halt_h),  32'd1);
    idle();
    pop_chk("halt_pop1", 8'h01);
    pop_chk("halt_pop2", 8'h02);
    pop_chk("halt_pop3", 8'h03);
    pop_chk("halt_pop4", 8'h04);
    chk("halt_drained", 32'(usage_h), 32'd0);

    // Overflow: acks beyond free space are dropped and counted
    push(2'b11, 8'h32, 8'h31);
    push(2'b01, 8'h00, 8'h33);
    cfi = 2'b11; ack = 2'b11; log_in = {8'h22, 8'h11};
    #1 chk("drop_halt_d", 32'(halt_d), 32'd0);
    chk("drop_halt_h",    32'(halt_h), 32'd1);
    step();
    chk("drop_usage", 32'(usage_d), 32'd4);
    chk("drop_ovf1",  32'(ovf_d),   32'd1);
    chk("drop_ovf1h", 32'(ovf_h),   32'd1);
    step(); idle();
    chk("drop_ovf3",   32'(ovf_d),   32'd3);
    chk("drop_usage4", 32'(usage_d), 32'd4);
    #1 chk("drop_head_d", 32'(data_d), 32'h31);
    pop_chk("drop_pop1", 8'h31);
    pop_chk("drop_pop2", 8'h32);
    pop_chk("drop_pop3", 8'h33);
    pop_chk("drop_pop4", 8'h11);
    chk("drop_drained", 32'(usage_d), 32'd0);

    // Wrap with push and pop in the same cycle at usage 2
    push(2'b01, 8'h00, 8'h61);
    push(2'b01, 8'h00, 8'h62);
    chk("wrap_usage", 32'(usage_h), 32'd2);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] nv;
      nv  = 8'h63 + 8'(i);
      cfi = 2'b01; ack = 2'b01; log_in = {8'h00, nv}; ready = 1'b1;
      step(); idle();
      chk("wrap_conc_usage", 32'(usage_h), 32'd2);
      chk("wrap_conc_head",  32'(data_h),  32'(nv - 8'd1));
    end
    pop_chk("wrap_pop5", 8'h65);
    pop_chk("wrap_pop6", 8'h66);
    chk("wrap_empty", 32'(valid_h), 32'd0);

    // Flush discards contents and same-cycle push/pop, keeps overflow count
    push(2'b11, 8'h72, 8'h71);
    push(2'b01, 8'h00, 8'h73);
    flush = 1'b1; cfi = 2'b01; ack = 2'b01; ready = 1'b1; log_in = {8'h00, 8'h74};
    #1 chk("flush_halt", 32'(halt_h), 32'd0);
    step(); idle();
    chk("flush_usage", 32'(usage_h), 32'd0);
    chk("flush_valid", 32'(valid_h), 32'd0);
    chk("flush_ovf",   32'(ovf_h),   32'd3);
    push(2'b01, 8'h00, 8'h81);
    chk("post_flush_usage", 32'(usage_h), 32'd1);
    chk("post_flush_head",  32'(data_h),  32'h81);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_usage", 32'(usage_h), 32'd0);
    chk("arst_valid", 32'(valid_h), 32'd0);
    chk("arst_ovf",   32'(ovf_d),   32'd0);
    chk("arst_halt",  32'(halt_h),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
